world_clock_ctrl: RTL
=====================

# world_clock_ctrl

Sequencer for the world-time display path. It owns the city index that selects an entry from the city table. It reads back that entry's 6-character name and hour offset, and computes the local hour from the base time. It streams a 12-character text line ("NNNNNN HH:MM") to the LCD character writer over a valid/ready handshake, redrawing on city change, on a minute tick, and after reset.

## Interface
- N_CITY, default 3: number of table entries; index wraps N_CITY-1 -> 0.
- IDX_W, default 4: width of city_idx; must satisfy 2^IDX_W >= N_CITY.
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- btn_next  in  1  single-cycle pulse: advance to the next city (debounced upstream).
- min_tick  in  1  single-cycle pulse: base time changed, redraw.
- base_hour  in  5  base hour, 0..23.
- base_min  in  6  base minute, 0..59.
- city_idx  out  IDX_W  registered select into the city table.
- name  in  48  city name, 6 ASCII bytes; name[7:0] is the first (leftmost) character.
- diff  in  7  signed two's-complement hour offset, valid range -23..+23.
- lcd_char  out  8  ASCII character.
- lcd_pos  out  4  column of lcd_char, 0..11.
- lcd_valid  out  1  character offered.
- lcd_ready  in  1  writer accepts; a transfer happens on lcd_valid && lcd_ready.
- busy  out  1  high in every state except IDLE.
- local_hour  out  5  last computed local hour, 0..23.

## Operation
- State machine: IDLE -> LOAD -> CALC -> SEND -> IDLE.
- IDLE: if pend_next is set, city_idx advances (wrapping) and both pending flags clear; go to LOAD. Else if pend_ref is set, clear it and go to LOAD. Else stay.
- LOAD: one wait cycle so the combinational table output settles for the new city_idx.
- CALC: snapshot name, base_min, and the computed hour into a line buffer. base_hour/base_min changes after this cycle do not affect the line in flight.
- SEND: offer characters for pos 0..11 in order.
  - Pos 0..5: name bytes [7:0], [15:8], ... [47:40].
  - Pos 6: 8'h20.
  - Pos 7..8: hour tens and units as 8'h30+digit.
  - Pos 9: 8'h3A.
  - Pos 10..11: minute tens and units as 8'h30+digit.
- Hour arithmetic: s = base_hour + sign-extended diff, computed at 7 bits signed. If s < 0, add 24. If s >= 24, subtract 24. A single correction covers the full input range, giving s in 0..23.
- A btn_next or min_tick seen in any state other than IDLE sets pend_next or pend_ref respectively. It never aborts the current line.
- A btn_next seen in IDLE acts in the same cycle, following the IDLE rules above. min_tick seen in IDLE behaves the same way.
- Multiple btn_next pulses during one line collapse to a single advance.
- Reset: all registers clear and pend_ref = 1, so the first line for city 0 starts right after reset is released.
- Reset asserted mid-SEND drops the line immediately. No partial resume.

## Timing
- Reset values:
  - city_idx = 0
  - lcd_valid = 0
  - lcd_char = 8'h20
  - lcd_pos = 0
  - busy = 0
  - local_hour = 0
  - state = IDLE
  - pend_next = 0
  - pend_ref = 1
- btn_next sampled high in IDLE at edge t:
  - city_idx changes and busy rises at t+1 (LOAD).
  - CALC at t+2.
  - lcd_valid rises at t+3, with lcd_pos = 0.
- lcd_char/lcd_pos are held stable while lcd_valid && !lcd_ready.
- After an accepted transfer, the next character is presented on the following cycle with no bubble. With lcd_ready held high, lcd_valid stays high for exactly 12 consecutive cycles.
- When the pos-11 transfer is accepted, lcd_valid drops and state returns to IDLE on the next edge. busy drops on that edge.
- If a pending flag is set on return to IDLE, LOAD is entered one cycle later (one IDLE cycle).
- local_hour updates at the end of CALC and holds until the next CALC.

## Test plan
- Reset release, table entry 0 = "London" (name = 48'h6E6F646E6F4C), diff = -9, base 05:07, lcd_ready = 1 -> city_idx = 0; 12 chars "London 20:07", pos 0..11; local_hour = 20; busy low afterwards.
- Wrap high: diff = +5, base 23:59 -> line hour "04", minute "59", local_hour = 4.
- Back-pressure: toggle lcd_ready 1/0 every cycle -> each char held while not ready, no char skipped or repeated, exactly 12 transfers.
- Two btn_next pulses plus one min_tick during SEND of city 0 (N_CITY = 3) -> current line completes unchanged. Exactly one new line follows for city_idx = 1. No third line.
- Index wrap: btn_next in IDLE with city_idx = 2, N_CITY = 3 -> city_idx = 0, first lcd_valid 3 cycles after the pulse.
- rst asserted at pos 5 of a line -> next cycle lcd_valid = 0, city_idx = 0, busy = 0. After release, a fresh line starts at pos 0.

Source files
------------

// File: rtl/world_clock_ctrl_if.sv
// LCD character-writer link used by world_clock_ctrl.
// The controller offers one ASCII character and its column. The writer
// takes it on any rising edge where lcd_valid && lcd_ready.
//   lcd_char  : ASCII character being offered
//   lcd_pos   : column of lcd_char, 0..11
//   lcd_valid : character offered (controller -> writer)
//   lcd_ready : writer accepts (writer -> controller)
interface world_clock_ctrl_if;
    logic [7:0] lcd_char;
    logic [3:0] lcd_pos;
    logic       lcd_valid;
    logic       lcd_ready;

    modport master (
        output lcd_char,
        output lcd_pos,
        output lcd_valid,
        input  lcd_ready
    );

    modport slave (
        input  lcd_char,
        input  lcd_pos,
        input  lcd_valid,
        output lcd_ready
    );
endinterface

// File: rtl/world_clock_ctrl.sv
// World-time display sequencer.
// The block owns the city index into an external city table. It reads back
// the selected entry's 6-character name and hour offset, and works out the
// local hour from the base time. It then streams the 12-character line
// "NNNNNN HH:MM" to the LCD writer.
// A redraw is requested by a city change, by a minute tick, or by reset.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   btn_next             : pulse, advance to the next city (wraps N_CITY-1 -> 0)
//   min_tick             : pulse, base time changed, redraw
//   base_hour, base_min  : base time, 0..23 and 0..59
//   city_idx             : registered select into the city table
//   name, diff           : table entry for city_idx, holding the name bytes
//                          (name[7:0] leftmost) and a signed hour offset
//   lcd                  : character stream to the LCD writer (master side)
//   busy                 : high whenever a line is being prepared or sent
//   local_hour           : local hour of the most recent line, 0..23
module world_clock_ctrl #(
    parameter int N_CITY = 3,
    parameter int IDX_W  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    btn_next,
    input  logic                    min_tick,
    input  logic [4:0]              base_hour,
    input  logic [5:0]              base_min,
    output logic [IDX_W-1:0]        city_idx,
    input  logic [47:0]             name,
    input  logic signed [6:0]       diff,
    world_clock_ctrl_if.master      lcd,
    output logic                    busy,
    output logic [4:0]              local_hour
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        SEND = 2'd3
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        pend_next;
    logic        pend_ref;
    logic        take_next;
    logic        take_ref;

    logic [47:0] line_name;
    logic [5:0]  line_min;
    logic [3:0]  pos;

    logic signed [6:0] hour_sum;
    logic signed [6:0] hour_fix;
    logic [4:0]        calc_hour;

    logic [7:0]  hour_ext;
    logic [7:0]  min_ext;
    logic [7:0]  char_out;

    logic [IDX_W-1:0] idx_wrapped;

    // Local hour from base hour and signed offset. The sum lies in -23..46,
    // so one correction by 24 in either direction always lands in 0..23.
    always_comb begin
        hour_sum = $signed({2'b00, base_hour}) + diff;
        hour_fix = hour_sum;
        if (hour_sum < 7'sd0) begin
            hour_fix = hour_sum + 7'sd24;
        end else if (hour_sum >= 7'sd24) begin
            hour_fix = hour_sum - 7'sd24;
        end
        calc_hour = hour_fix[4:0];
    end

    assign idx_wrapped = (city_idx == IDX_W'(N_CITY - 1)) ? '0 : city_idx + 1'b1;

    // Next-state logic. In IDLE a live pulse counts the same as a pending flag.
    // A city advance takes priority, and it also satisfies a pending redraw.
    always_comb begin
        next_state = state;
        take_next  = 1'b0;
        take_ref   = 1'b0;
        unique case (state)
            IDLE: begin
                if (pend_next || btn_next) begin
                    take_next  = 1'b1;
                    next_state = LOAD;
                end else if (pend_ref || min_tick) begin
                    take_ref   = 1'b1;
                    next_state = LOAD;
                end
            end
            LOAD: next_state = CALC;
            CALC: next_state = SEND;
            SEND: begin
                if (lcd.lcd_ready && (pos == 4'd11)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // City index, pending requests, the line snapshot and the column counter.
    // A reset clears everything except pend_ref. pend_ref is set so that the
    // first line for city 0 starts as soon as reset is released.
    always_ff @(posedge clk) begin
        if (rst) begin
            city_idx   <= '0;
            pend_next  <= 1'b0;
            pend_ref   <= 1'b1;
            line_name  <= '0;
            line_min   <= '0;
            local_hour <= '0;
            pos        <= '0;
        end else begin
            if (state == IDLE) begin
                if (take_next) begin
                    city_idx  <= idx_wrapped;
                    pend_next <= 1'b0;
                    pend_ref  <= 1'b0;
                end else if (take_ref) begin
                    pend_ref  <= 1'b0;
                end
            end else begin
                if (btn_next) begin
                    pend_next <= 1'b1;
                end
                if (min_tick) begin
                    pend_ref <= 1'b1;
                end
            end

            if (state == CALC) begin
                line_name  <= name;
                line_min   <= base_min;
                local_hour <= calc_hour;
            end

            if ((state == SEND) && lcd.lcd_ready) begin
                pos <= (pos == 4'd11) ? 4'd0 : pos + 4'd1;
            end
        end
    end

    assign hour_ext = {3'b000, local_hour};
    assign min_ext  = {2'b00, line_min};

    // Character for the current column. Outside SEND a space is presented.
    always_comb begin
        char_out = 8'h20;
        if (state == SEND) begin
            unique case (pos)
                4'd0:    char_out = line_name[7:0];
                4'd1:    char_out = line_name[15:8];
                4'd2:    char_out = line_name[23:16];
                4'd3:    char_out = line_name[31:24];
                4'd4:    char_out = line_name[39:32];
                4'd5:    char_out = line_name[47:40];
                4'd6:    char_out = 8'h20;
                4'd7:    char_out = 8'h30 + (hour_ext / 8'd10);
                4'd8:    char_out = 8'h30 + (hour_ext % 8'd10);
                4'd9:    char_out = 8'h3A;
                4'd10:   char_out = 8'h30 + (min_ext / 8'd10);
                4'd11:   char_out = 8'h30 + (min_ext % 8'd10);
                default: char_out = 8'h20;
            endcase
        end
    end

    assign lcd.lcd_char  = char_out;
    assign lcd.lcd_pos   = pos;
    assign lcd.lcd_valid = (state == SEND);
    assign busy          = (state != IDLE);

endmodule
